mio_bus_arbiter: RTL and testbench
==================================

Name: mio_bus_arbiter

Overview:
Shares the single memory/IO bus, with its MIO_ready wait-state handshake, between the instruction-fetch port and the data-memory port of the pipelined CPU.
- Grants one requester at a time and holds the bus until the slave answers or a watchdog expires.
- Returns read data and a one-cycle ack to the winner.
- Drives pipeline stall requests while either port is waiting.
- Sits between the IF/MEM stages and the MIO bus controller.

Parameters:
AW, 32, address width
DW, 32, data width
WAIT_MAX, 15, max cycles to wait for MIO_ready before aborting (1..255)
STARVE_MAX, 3, consecutive data grants allowed while fetch is pending before fetch is forced (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DW  fetched word, valid with if_ack
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_ack  out  1  one-cycle data completion pulse
dm_rdata  out  DW  load data, valid with dm_ack
bus_req  out  1  bus transaction active
bus_we  out  1  bus write strobe
bus_addr  out  AW  bus address
bus_wdata  out  DW  bus write data
bus_rdata  in  DW  bus read data
MIO_ready  in  1  slave completion, sampled only while bus_req = 1
bus_err  out  1  one-cycle pulse with ack when the watchdog aborted the transaction
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  dm_req & ~dm_ack (combinational)

Behaviour:
- Reset: state IDLE; all registered outputs 0 (bus_*, if_ack, dm_ack, if_rdata, dm_rdata, bus_err); wait_cnt = 0; starve_cnt = 0.
- Reset asserted mid-transaction aborts it immediately. No ack is issued; the requester re-requests after reset.
- FSM states: IDLE, BUS_D, BUS_I, ACK_D, ACK_I.
- IDLE arbitration:
  - dm_req only -> BUS_D.
  - if_req only -> BUS_I.
  - Both -> BUS_D, unless starve_cnt == STARVE_MAX, in which case BUS_I.
  - Neither -> stay in IDLE.
- Grant entry: latch addr/we/wdata into bus_addr/bus_we/bus_wdata. Fetch is always bus_we = 0 and bus_wdata = 0. Set bus_req = 1 and wait_cnt = 0.
- starve_cnt:
  - Increments on a data grant while if_req = 1, saturating at STARVE_MAX.
  - Clears on any fetch grant.
  - Clears on a data grant with if_req = 0.
- BUS_x with MIO_ready = 1:
  - Capture bus_rdata into the port's rdata (stores capture too; the value is don't-care).
  - Clear bus_req and bus_we, go to ACK_x.
- BUS_x with MIO_ready = 0: wait_cnt++. When wait_cnt == WAIT_MAX:
  - Clear bus_req, set the port's rdata = 0 and bus_err = 1.
  - Go to ACK_x.
- ACK_x: the port's ack = 1 for exactly this cycle; bus_err stays high this cycle if set. Then go to IDLE; ack and bus_err return to 0.
- Latency: request sampled in IDLE at edge N; bus_req is high from cycle N+1. With MIO_ready in cycle N+1, ack is high in cycle N+2. Minimum 3 cycles per transaction.
- Requesters drop or change req in the cycle after ack. A req still high in IDLE is a new request.
- Address and data are latched at grant; changes on the request inputs during BUS_x are ignored.
- rdata holds its value until the next completion for that port.
- MIO_ready high while bus_req = 0 is ignored.
- Inputs changing during ACK_x are not sampled.

Decomposition:
- Shared package cpu_bus_pkg: FSM state encoding (3-bit localparams) and the default WAIT_MAX/STARVE_MAX constants.
- One natural sub-module, mio_watchdog: wait counter with clear, enable and expired output, reusable by the DMA/IO controllers.

Test Plan:
1. Fetch alone, MIO_ready high immediately, if_addr=0x0000_0040, bus_rdata=0x2008_0005 -> bus_req high 1 cycle, if_ack in cycle 2, if_rdata=0x2008_0005, bus_we=0.
2. Store with 3 wait states: dm_we=1, dm_addr=0x0000_0100, dm_wdata=0xDEAD_BEEF, MIO_ready high on 4th bus cycle -> bus_we/bus_wdata stable for 4 cycles, dm_ack 1 cycle later, stall_mem high throughout.
3. Simultaneous if_req/dm_req held continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I…; if_ack never missing for more than 3 data acks.
4. MIO_ready never asserted, WAIT_MAX=15 -> bus_req drops after 15 bus cycles; dm_ack, bus_err and dm_rdata=0 in the same cycle; next request serviced normally.
5. rst asserted in BUS_I mid-wait -> all outputs 0 asynchronously, no if_ack; after release, re-request completes normally.
6. Back-to-back loads with MIO_ready tied high -> one dm_ack every 3 cycles; dm_rdata tracks the bus_rdata sequence 0x1, 0x2, 0x3.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared bus-arbitration types and defaults for the CPU memory/IO path.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUS_D = 3'd1,
    ST_BUS_I = 3'd2,
    ST_ACK_D = 3'd3,
    ST_ACK_I = 3'd4
  } bus_state_t;

  localparam int unsigned WAIT_MAX_DEF   = 15;
  localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mio_watchdog.sv
// Wait-state counter: clear restarts it, enable counts one waited cycle,
// expired flags the cycle in which the count would reach MAX.
module mio_watchdog #(
  parameter int unsigned MAX = 15,
  parameter int unsigned W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(MAX);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable && wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the MAX-th waited cycle so the abort lands on that same edge.
  assign expired = enable && (wait_cnt == LIMIT - 1'b1);

endmodule

// File: rtl/mio_bus_arbiter.sv
// Arbitrates the single MIO bus between instruction fetch and data memory,
// with a wait-state watchdog and fetch anti-starvation.
module mio_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned WAIT_MAX   = WAIT_MAX_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          MIO_ready,
  output logic          bus_err,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  bus_state_t state;
  logic [3:0] starve_cnt;
  logic       in_bus;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;
  logic       pick_fetch;

  assign in_bus     = (state == ST_BUS_D) || (state == ST_BUS_I);
  assign wd_clear   = (state == ST_IDLE) && (if_req || dm_req);
  assign wd_enable  = in_bus && !MIO_ready;
  assign pick_fetch = if_req && (!dm_req || starve_cnt == STARVE_LIM);

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  mio_watchdog #(
    .MAX (WAIT_MAX),
    .W   (8)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_err    <= 1'b0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_fetch) begin
            state      <= ST_BUS_I;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= if_addr;
            bus_wdata  <= '0;
            starve_cnt <= '0;
          end else if (dm_req) begin
            state     <= ST_BUS_D;
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ST_BUS_D, ST_BUS_I: begin
          if (MIO_ready || wd_expired) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_err <= !MIO_ready;
            if (state == ST_BUS_D) begin
              state    <= ST_ACK_D;
              dm_ack   <= 1'b1;
              dm_rdata <= MIO_ready ? bus_rdata : '0;
            end else begin
              state    <= ST_ACK_I;
              if_ack   <= 1'b1;
              if_rdata <= MIO_ready ? bus_rdata : '0;
            end
          end
        end
        ST_ACK_D, ST_ACK_I: begin
          state   <= ST_IDLE;
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
          bus_err <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: single transfers, wait states,
// starvation order, watchdog abort, async reset and back-to-back loads.
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        MIO_ready;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter #(
    .AW         (32),
    .DW         (32),
    .WAIT_MAX   (15),
    .STARVE_MAX (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .MIO_ready (MIO_ready),
    .bus_err   (bus_err),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fetch_order;
    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; bus_rdata = '0; MIO_ready = 0;
    step(); step();
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_if_ack", 32'(if_ack), 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    step();

    // 1: fetch, immediate ready
    if_req = 1; if_addr = 32'h0000_0040; MIO_ready = 1; bus_rdata = 32'h2008_0005;
    #1 chk("t1_stall_if", 32'(stall_if), 1);
    step();
    chk("t1_bus_req", 32'(bus_req), 1);
    chk("t1_bus_addr", bus_addr, 32'h0000_0040);
    chk("t1_bus_we", 32'(bus_we), 0);
    step();
    chk("t1_if_ack", 32'(if_ack), 1);
    chk("t1_if_rdata", if_rdata, 32'h2008_0005);
    chk("t1_bus_req_off", 32'(bus_req), 0);
    chk("t1_stall_if_ack", 32'(stall_if), 0);
    if_req = 0;
    step();
    chk("t1_if_ack_off", 32'(if_ack), 0);

    // 2: store with 3 wait states
    MIO_ready = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) MIO_ready = 1;
      dm_wdata = 32'h1111_1111;
      chk("t2_bus_req", 32'(bus_req), 1);
      chk("t2_bus_we", 32'(bus_we), 1);
      chk("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("t2_stall_mem", 32'(stall_mem), 1);
      chk("t2_dm_ack_wait", 32'(dm_ack), 0);
    end
    step();
    chk("t2_dm_ack", 32'(dm_ack), 1);
    chk("t2_bus_req_off", 32'(bus_req), 0);
    chk("t2_bus_err", 32'(bus_err), 0);
    dm_req = 0; dm_we = 0;
    step();
    chk("t2_dm_ack_off", 32'(dm_ack), 0);

    // 3: both requesting, expected grants D,D,D,I,D,D,D,I (bit i = fetch)
    fetch_order = 8'b1000_1000;
    if_req = 1; if_addr = 32'h0000_0200; dm_req = 1; dm_addr = 32'h0000_0300;
    bus_rdata = 32'h0000_0055; MIO_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_bus_addr", bus_addr, fetch_order[i] ? 32'h0000_0200 : 32'h0000_0300);
      step();
      chk("t3_if_ack", 32'(if_ack), 32'(fetch_order[i]));
      chk("t3_dm_ack", 32'(dm_ack), 32'(!fetch_order[i]));
      step();
    end
    if_req = 0; dm_req = 0;
    step();

    // 4: watchdog abort
    MIO_ready = 0; dm_req = 1; dm_addr = 32'h0000_0400; bus_rdata = 32'hAAAA_AAAA;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("t4_bus_req", 32'(bus_req), 1);
      chk("t4_dm_ack_wait", 32'(dm_ack), 0);
    end
    step();
    chk("t4_bus_req_off", 32'(bus_req), 0);
    chk("t4_dm_ack", 32'(dm_ack), 1);
    chk("t4_bus_err", 32'(bus_err), 1);
    chk("t4_dm_rdata", dm_rdata, 0);
    dm_req = 0;
    step();
    chk("t4_bus_err_off", 32'(bus_err), 0);
    dm_req = 1; MIO_ready = 1; bus_rdata = 32'h0000_7777;
    step(); step();
    chk("t4_next_ack", 32'(dm_ack), 1);
    chk("t4_next_err", 32'(bus_err), 0);
    chk("t4_next_rdata", dm_rdata, 32'h0000_7777);
    dm_req = 0;
    step();

    // 5: async reset mid-wait in BUS_I
    MIO_ready = 0; if_req = 1; if_addr = 32'h0000_0500; bus_rdata = 32'h0000_0999;
    step(); step(); step();
    chk("t5_bus_req_pre", 32'(bus_req), 1);
    #2 rst = 1;
    #1;
    chk("t5_bus_req_rst", 32'(bus_req), 0);
    chk("t5_bus_addr_rst", bus_addr, 0);
    chk("t5_dm_rdata_rst", dm_rdata, 0);
    chk("t5_if_ack_rst", 32'(if_ack), 0);
    step();
    chk("t5_if_ack_hold", 32'(if_ack), 0);
    rst = 0; MIO_ready = 1;
    step();
    chk("t5_bus_addr_re", bus_addr, 32'h0000_0500);
    step();
    chk("t5_if_ack_re", 32'(if_ack), 1);
    chk("t5_if_rdata_re", if_rdata, 32'h0000_0999);
    if_req = 0;
    step();

    // 6: back-to-back loads, ready tied high
    dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0600;
    for (int i = 1; i <= 3; i++) begin
      bus_rdata = 32'(i);
      step();
      chk("t6_dm_ack_bus", 32'(dm_ack), 0);
      step();
      chk("t6_dm_ack", 32'(dm_ack), 1);
      chk("t6_dm_rdata", dm_rdata, 32'(i));
      step();
      chk("t6_dm_ack_idle", 32'(dm_ack), 0);
    end
    dm_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
